// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   mdu_op_e    - decoder MDUOp encodings (MADD, code 7, is only honoured
//                 when MDU_MADD_EN is defined; otherwise it acts as NOP)
//   mdu_state_e - MDU sequencing FSM states
//   CNT_W       - width of the busy counter
//   op_is_div   - selects the DIV_CYCLES busy period
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MADD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned CNT_W = 32;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
// Ports:
//   op_i   [2:0]  MDUOp selecting the operation
//   rs_i   [31:0] rs operand (multiplicand / dividend)
//   rt_i   [31:0] rt operand (multiplier / divisor)
//   res_o  [63:0] {HI,LO} result: product, or {remainder,quotient}
//   div0_o        DIV/DIVU with a zero divisor (result must be discarded)
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               sdiv;
  logic        [31:0] abs_rs;
  logic        [31:0] abs_rt;
  logic        [31:0] divisor;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] quo;
  logic        [31:0] rem;

  always_comb begin
    prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    prod_u = {32'b0, rs_i} * {32'b0, rt_i};

    // Signed division runs on magnitudes so 0x80000000 / -1 needs no special
    // case: |a| = 0x80000000, quotient stays positive-signed 0x80000000.
    sdiv    = (op_i == MDU_DIV);
    abs_rs  = (sdiv && rs_i[31]) ? (32'd0 - rs_i) : rs_i;
    abs_rt  = (sdiv && rt_i[31]) ? (32'd0 - rt_i) : rt_i;
    divisor = (abs_rt == '0) ? 32'd1 : abs_rt;
    q_mag   = abs_rs / divisor;
    r_mag   = abs_rs % divisor;
    quo     = (sdiv && (rs_i[31] ^ rt_i[31])) ? (32'd0 - q_mag) : q_mag;
    rem     = (sdiv && rs_i[31]) ? (32'd0 - r_mag) : r_mag;

    res_o  = '0;
    div0_o = 1'b0;
    case (op_i)
      MDU_MULT, MDU_MADD: res_o = $unsigned(prod_s);
      MDU_MULTU:          res_o = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res_o  = {rem, quo};
        div0_o = (rt_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit owning HI/LO and a multi-cycle busy timer.
// Parameters: MULT_CYCLES (MULT/MULTU/MADD busy cycles), DIV_CYCLES (DIV/DIVU).
// Ports:
//   clk     sole clock, rising edge
//   reset   asynchronous active-low reset
//   start   decoder MDU_start for the instruction in E
//   mdu_op  decoder MDUOp
//   rs_val  forwarded rs operand
//   rt_val  forwarded rt operand
//   req     flush of the E-stage instruction this cycle
//   busy    operation in flight (registered)
//   hi, lo  HI/LO registers
// Configuration: define MDU_MADD_EN to enable MADD (code 7); otherwise code 7
// is a NOP.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      pend_q;
  logic             dz_q;
`ifdef MDU_MADD_EN
  logic             madd_q;
`endif

  logic [63:0]      arith_res;
  logic             arith_div0;
  logic             op_starts;
  logic [CNT_W-1:0] cnt_load;
  logic [63:0]      commit_d;

  mdu_arith u_arith (
    .op_i   (mdu_op),
    .rs_i   (rs_val),
    .rt_i   (rt_val),
    .res_o  (arith_res),
    .div0_o (arith_div0)
  );

  always_comb begin
    op_starts = 1'b0;
    case (mdu_op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: op_starts = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD: op_starts = 1'b1;
`endif
      default: ;
    endcase
    cnt_load = op_is_div(mdu_op) ? DIV_CYCLES : MULT_CYCLES;
  end

  // MADD accumulates onto HI/LO as they stand at commit, not at start.
  always_comb begin
`ifdef MDU_MADD_EN
    commit_d = madd_q ? ({hi_q, lo_q} + pend_q) : pend_q;
`else
    commit_d = pend_q;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!req) begin
            if (start && op_starts) begin
              state_q <= S_RUN;
              cnt_q   <= cnt_load;
              busy_q  <= 1'b1;
              pend_q  <= arith_res;
              dz_q    <= arith_div0;
`ifdef MDU_MADD_EN
              madd_q  <= (mdu_op == MDU_MADD);
`endif
            end else if (mdu_op == MDU_MTHI) begin
              hi_q <= rs_val;
            end else if (mdu_op == MDU_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        S_RUN: begin
          // start/MTHI/MTLO/req are all ignored here: the running op belongs
          // to an older, committed instruction.
          if (cnt_q == 1) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            if (!dz_q) begin
              {hi_q, lo_q} <= commit_d;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .req    (req),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic starts_op(input logic [2:0] op);
`ifdef MDU_MADD_EN
    if (op == 3'd7) return 1'b1;
`endif
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
  endfunction

  function automatic int unsigned op_cycles(input logic [2:0] op);
    return ((op == 3'd3) || (op == 3'd4)) ? DC : MC;
  endfunction

  // Architectural effect of one accepted op, straight from the ISA rules.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: {hi_m, lo_m} = sa * sb;
      3'd2: begin up = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = up; end
      3'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
`ifdef MDU_MADD_EN
      3'd7: {hi_m, lo_m} = {hi_m, lo_m} + 64'(sa * sb);
`endif
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    start = 1'b0; mdu_op = 3'd0; req = 1'b0;
  endtask

  // Issue one op at a single edge; if it is a multi-cycle op, measure the busy
  // window (optionally with junk inputs while running) and check the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noisy);
    int n;
    @(negedge clk);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b; req = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    if (starts_op(op)) begin
      check("busy_rise", {31'b0, busy}, 32'd1);
      check("hold_hi", hi, hi_m);
      check("hold_lo", lo, lo_m);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        if (noisy) begin
          start = 1'($urandom); mdu_op = 3'($urandom); req = 1'($urandom);
          rs_val = $urandom; rt_val = $urandom;
        end
        @(posedge clk); #1;
        n++;
      end
      idle_inputs();
      check("busy_len", 32'(n), op_cycles(op));
    end else begin
      check("no_busy", {31'b0, busy}, 32'd0);
    end
    model_apply(op, a, b);
    check("hi", hi, hi_m);
    check("lo", lo, lo_m);
  endtask

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b0; idle_inputs(); rs_val = '0; rt_val = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_hi_k", hi, 32'hFFFFFFFF);
    check("mult_lo_k", lo, 32'hFFFFFFFA);
    run_op(3'd4, 32'd7, 32'd2, 1'b0);
    check("divu_lo_k", lo, 32'd3);
    check("divu_hi_k", hi, 32'd1);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_lo_k", lo, 32'hFFFFFFFD);
    check("div_hi_k", hi, 32'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("ovf_lo_k", lo, 32'h80000000);
    check("ovf_hi_k", hi, 32'd0);
    run_op(3'd1, 32'h00012345, 32'h0000ABCD, 1'b0);
    run_op(3'd3, 32'd99, 32'd0, 1'b0);
    run_op(3'd4, 32'hDEADBEEF, 32'd0, 1'b1);

    // MTHI flushed by req, then taken
    @(negedge clk); mdu_op = 3'd5; rs_val = 32'h1234; req = 1'b1;
    @(posedge clk); #1; idle_inputs();
    check("mthi_req_hi", hi, hi_m);
    run_op(3'd5, 32'h1234, 32'd0, 1'b0);
    check("mthi_hi_k", hi, 32'h1234);

    // start flushed by req
    @(negedge clk); start = 1'b1; mdu_op = 3'd1; rs_val = 32'd9; rt_val = 32'd9; req = 1'b1;
    @(posedge clk); #1; idle_inputs();
    check("start_req_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check("start_req_lo", lo, lo_m);

    // req and a second start during RUN are ignored
    @(negedge clk); start = 1'b1; mdu_op = 3'd1; rs_val = 32'h00010003; rt_val = 32'd7;
    @(posedge clk); #1; idle_inputs();
    @(posedge clk); #1; req = 1'b1;
    @(posedge clk); #1; req = 1'b0; start = 1'b1; mdu_op = 3'd4; rs_val = 32'd100; rt_val = 32'd3;
    @(posedge clk); #1; idle_inputs();
    n = 3;
    while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    check("req_run_len", 32'(n), MC);
    model_apply(3'd1, 32'h00010003, 32'd7);
    check("req_run_hi", hi, hi_m);
    check("req_run_lo", lo, lo_m);
    @(posedge clk); #1;
    check("no_restart", {31'b0, busy}, 32'd0);
    check("no_restart_lo", lo, lo_m);

    // randomized mix, back-to-back, junk inputs while running
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h80000000;
      if ($urandom_range(0, 4) == 0) b = 32'hFFFFFFFF;
      run_op(op, a, b, 1'($urandom));
    end

`ifdef MDU_MADD_EN
    run_op(3'd5, 32'd0, 32'd0, 1'b0);
    run_op(3'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_op(3'd7, 32'd1, 32'd1, 1'b0);
    check("madd_hi_k", hi, 32'd1);
    check("madd_lo_k", lo, 32'd0);
`else
    run_op(3'd7, 32'd5, 32'd6, 1'b0);
    check("op7_nop_busy", {31'b0, busy}, 32'd0);
`endif

    // reset mid-run aborts without commit
    run_op(3'd5, 32'hA5A5A5A5, 32'd0, 1'b0);
    run_op(3'd6, 32'h5A5A5A5A, 32'd0, 1'b0);
    @(negedge clk); start = 1'b1; mdu_op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1; idle_inputs();
    repeat (2) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    hi_m = '0; lo_m = '0;
    repeat (8) @(posedge clk);
    #1;
    check("arst_nocommit_busy", {31'b0, busy}, 32'd0);
    check("arst_nocommit_hi", hi, hi_m);
    check("arst_nocommit_lo", lo, lo_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
